// File: rtl/stump_control.sv
// stump_control
// Sequencing controller for the Stump datapath. Holds the instruction
// register and walks each instruction through FETCH, EXECUTE and (for
// loads/stores) MEMORY, decoding the instruction into register-file, ALU,
// flag and memory control lines. R7 is the program counter.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   data_in      memory read data (instruction in FETCH, load data in MEMORY)
//   mem_ready    memory completes the current access this cycle
//   cc           current flags {N,Z,V,C}
//   fetch/execute/memory  one-hot state indicators
//   ir           instruction register
//   reg_write, dest, srcA, srcB          register bank control
//   alu_func, shift_op, opB_imm, imm     ALU / operand-B control
//   cc_en, addr_en, addr_sel, reg_data_sel  flag, address and writeback select
//   mem_ren, mem_wen                     memory strobes
module stump_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        mem_ready,
  input  logic [3:0]  cc,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic [15:0] ir,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [2:0]  alu_func,
  output logic [1:0]  shift_op,
  output logic        opB_imm,
  output logic [15:0] imm,
  output logic        cc_en,
  output logic        addr_en,
  output logic        addr_sel,
  output logic        reg_data_sel,
  output logic        mem_ren,
  output logic        mem_wen
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10
  } state_t;

  state_t      state_r;
  logic [15:0] ir_r;

  logic [2:0] op_s;
  logic       type_s;
  logic       s_bit_s;
  logic [2:0] rd_s;
  logic [2:0] ra_s;
  logic [2:0] rb_s;
  logic [1:0] sh_s;
  logic [3:0] cond_s;
  logic [7:0] off8_s;

  logic reg_write_s;
  logic cc_en_s;
  logic addr_en_s;
  logic mem_ren_s;
  logic mem_wen_s;

  // Sign-extend the 5-bit ALU immediate.
  function automatic logic [15:0] sext5(input logic [4:0] v);
    sext5 = {{11{v[4]}}, v};
  endfunction

  // Sign-extend the 8-bit branch offset.
  function automatic logic [15:0] sext8(input logic [7:0] v);
    sext8 = {{8{v[7]}}, v};
  endfunction

  // Evaluate a branch condition against flags {N,Z,V,C}.
  function automatic logic cond_taken(input logic [3:0] cond_v, input logic [3:0] flags_v);
    logic n_v;
    logic z_v;
    logic v_v;
    logic c_v;
    n_v = flags_v[3];
    z_v = flags_v[2];
    v_v = flags_v[1];
    c_v = flags_v[0];
    case (cond_v)
      4'd0:    cond_taken = 1'b1;
      4'd1:    cond_taken = 1'b0;
      4'd2:    cond_taken = ~c_v & ~z_v;
      4'd3:    cond_taken = c_v | z_v;
      4'd4:    cond_taken = ~c_v;
      4'd5:    cond_taken = c_v;
      4'd6:    cond_taken = ~z_v;
      4'd7:    cond_taken = z_v;
      4'd8:    cond_taken = ~v_v;
      4'd9:    cond_taken = v_v;
      4'd10:   cond_taken = ~n_v;
      4'd11:   cond_taken = n_v;
      4'd12:   cond_taken = (n_v == v_v);
      4'd13:   cond_taken = (n_v != v_v);
      4'd14:   cond_taken = ~z_v & (n_v == v_v);
      4'd15:   cond_taken = z_v | (n_v != v_v);
      default: cond_taken = 1'b0;
    endcase
  endfunction

  assign op_s    = ir_r[15:13];
  assign type_s  = ir_r[12];
  assign s_bit_s = ir_r[11];
  assign rd_s    = ir_r[10:8];
  assign ra_s    = ir_r[7:5];
  assign rb_s    = ir_r[4:2];
  assign sh_s    = ir_r[1:0];
  assign cond_s  = ir_r[11:8];
  assign off8_s  = ir_r[7:0];

  assign ir = ir_r;

  // Write strobes are squashed while reset is held so an aborted
  // instruction can never disturb registers, flags or memory.
  assign reg_write = reg_write_s & rst;
  assign cc_en     = cc_en_s     & rst;
  assign addr_en   = addr_en_s   & rst;
  assign mem_ren   = mem_ren_s   & rst;
  assign mem_wen   = mem_wen_s   & rst;

  // State machine and instruction register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      ir_r    <= 16'h0000;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_r    <= data_in;
            state_r <= ST_EXECUTE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_EXECUTE: begin
          if (op_s == 3'b110) begin
            state_r <= ST_MEMORY;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_MEMORY: begin
          if (mem_ready) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_MEMORY;
          end
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

  // Control decode from current state and instruction.
  always_comb begin
    fetch        = 1'b0;
    execute      = 1'b0;
    memory       = 1'b0;
    dest         = 3'd0;
    srcA         = 3'd0;
    srcB         = 3'd0;
    alu_func     = 3'd0;
    shift_op     = 2'd0;
    opB_imm      = 1'b0;
    imm          = 16'h0000;
    addr_sel     = 1'b0;
    reg_data_sel = 1'b0;
    reg_write_s  = 1'b0;
    cc_en_s      = 1'b0;
    addr_en_s    = 1'b0;
    mem_ren_s    = 1'b0;
    mem_wen_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // PC+1 is written back only when the fetch actually completes.
        fetch       = 1'b1;
        srcA        = 3'd7;
        opB_imm     = 1'b1;
        imm         = 16'h0001;
        dest        = 3'd7;
        mem_ren_s   = 1'b1;
        reg_write_s = mem_ready;
      end
      ST_EXECUTE: begin
        execute = 1'b1;
        if (op_s == 3'b111) begin
          // Branch: target = (already incremented) PC + offset.
          srcA        = 3'd7;
          opB_imm     = 1'b1;
          imm         = sext8(off8_s);
          dest        = 3'd7;
          reg_write_s = cond_taken(cond_s, cc);
        end else begin
          srcA = ra_s;
          dest = rd_s;
          if (type_s) begin
            opB_imm = 1'b1;
            imm     = sext5(ir_r[4:0]);
          end else begin
            srcB     = rb_s;
            shift_op = sh_s;
          end
          if (op_s == 3'b110) begin
            // Load/store: ALU adds the address, result goes to the address register.
            addr_en_s = 1'b1;
          end else begin
            alu_func    = op_s;
            reg_write_s = 1'b1;
            cc_en_s     = s_bit_s;
          end
        end
      end
      ST_MEMORY: begin
        memory   = 1'b1;
        addr_sel = 1'b1;
        if (s_bit_s) begin
          mem_wen_s = 1'b1;
          srcA      = rd_s;
        end else begin
          mem_ren_s    = 1'b1;
          dest         = rd_s;
          reg_data_sel = 1'b1;
          reg_write_s  = mem_ready;
        end
      end
      default: begin
        fetch = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stump_control.sv
module tb_stump_control;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        mem_ready;
  logic [3:0]  cc;
  logic        fetch, execute, memory;
  logic [15:0] ir;
  logic        reg_write;
  logic [2:0]  dest, srcA, srcB, alu_func;
  logic [1:0]  shift_op;
  logic        opB_imm;
  logic [15:0] imm;
  logic        cc_en, addr_en, addr_sel, reg_data_sel, mem_ren, mem_wen;

  stump_control dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mem_ready(mem_ready), .cc(cc),
    .fetch(fetch), .execute(execute), .memory(memory), .ir(ir),
    .reg_write(reg_write), .dest(dest), .srcA(srcA), .srcB(srcB),
    .alu_func(alu_func), .shift_op(shift_op), .opB_imm(opB_imm), .imm(imm),
    .cc_en(cc_en), .addr_en(addr_en), .addr_sel(addr_sel),
    .reg_data_sel(reg_data_sel), .mem_ren(mem_ren), .mem_wen(mem_wen)
  );

  typedef struct packed {
    logic        fetch;
    logic        execute;
    logic        memory;
    logic [15:0] ir;
    logic        reg_write;
    logic [2:0]  dest;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [2:0]  alu_func;
    logic [1:0]  shift_op;
    logic        opB_imm;
    logic [15:0] imm;
    logic        cc_en;
    logic        addr_en;
    logic        addr_sel;
    logic        reg_data_sel;
    logic        mem_ren;
    logic        mem_wen;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [15:0] cur_ir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign extension written as plain integer arithmetic.
  function automatic logic [15:0] sx(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 16'(r);
  endfunction

  // Conditions come in complementary pairs: odd code = base, even = ~base.
  function automatic logic taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[3:1])
      3'd0:    base = 1'b0;
      3'd1:    base = c | z;
      3'd2:    base = c;
      3'd3:    base = z;
      3'd4:    base = v;
      3'd5:    base = n;
      3'd6:    base = n ^ v;
      default: base = z | (n ^ v);
    endcase
    return cond[0] ? base : ~base;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic [15:0] cur, input logic rdy, input logic in_reset);
    exp_t e;
    e = blank();
    e.fetch = 1'b1; e.ir = cur; e.srcA = 3'd7; e.opB_imm = 1'b1;
    e.imm = 16'h0001; e.dest = 3'd7;
    e.mem_ren   = ~in_reset;
    e.reg_write = rdy & ~in_reset;
    return e;
  endfunction

  function automatic exp_t exec_exp(input logic [15:0] w, input logic [3:0] f);
    exp_t e;
    int   op;
    e = blank();
    e.execute = 1'b1; e.ir = w;
    op = int'(w[15:13]);
    if (op == 7) begin
      e.srcA = 3'd7; e.opB_imm = 1'b1; e.imm = sx(int'(w[7:0]), 8);
      e.dest = 3'd7; e.reg_write = taken(w[11:8], f);
    end else begin
      e.srcA = w[7:5]; e.dest = w[10:8];
      if (w[12]) begin
        e.opB_imm = 1'b1; e.imm = sx(int'(w[4:0]), 5);
      end else begin
        e.srcB = w[4:2]; e.shift_op = w[1:0];
      end
      if (op == 6) begin
        e.addr_en = 1'b1;
      end else begin
        e.alu_func = w[15:13]; e.reg_write = 1'b1; e.cc_en = w[11];
      end
    end
    return e;
  endfunction

  function automatic exp_t mem_exp(input logic [15:0] w, input logic rdy);
    exp_t e;
    e = blank();
    e.memory = 1'b1; e.ir = w; e.addr_sel = 1'b1;
    if (w[11]) begin
      e.mem_wen = 1'b1; e.srcA = w[10:8];
    end else begin
      e.mem_ren = 1'b1; e.dest = w[10:8]; e.reg_data_sel = 1'b1; e.reg_write = rdy;
    end
    return e;
  endfunction

  // Drive one cycle's inputs (called just after a rising edge) and queue its expectation.
  task automatic cycle(input exp_t e, input string nm, input logic r_n, input logic rdy,
                       input logic [15:0] din, input logic [3:0] ccv);
    rst = r_n; mem_ready = rdy; data_in = din; cc = ccv;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] w, input int fstall, input int mstall, input logic [3:0] ccv);
    for (int i = 0; i < fstall; i++)
      cycle(fetch_exp(cur_ir, 1'b0, 1'b0), "fetch_stall", 1'b1, 1'b0, 16'($urandom), 4'($urandom));
    cycle(fetch_exp(cur_ir, 1'b1, 1'b0), "fetch_done", 1'b1, 1'b1, w, 4'($urandom));
    cur_ir = w;
    cycle(exec_exp(w, ccv), "execute", 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), ccv);
    if (w[15:13] == 3'b110) begin
      for (int i = 0; i < mstall; i++)
        cycle(mem_exp(w, 1'b0), "mem_stall", 1'b1, 1'b0, 16'($urandom), 4'($urandom));
      cycle(mem_exp(w, 1'b1), "mem_done", 1'b1, 1'b1, 16'($urandom), 4'($urandom));
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{fetch, execute, memory, ir, reg_write, dest, srcA, srcB, alu_func,
            shift_op, opB_imm, imm, cc_en, addr_en, addr_sel, reg_data_sel,
            mem_ren, mem_wen};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (ir=%h rw=%b dest=%0d srcA=%0d imm=%h) at %0t",
                 nm, a, e, ir, reg_write, dest, srcA, imm, $time);
      end
    end
  end

  initial begin
    exp_t rst_e;
    logic [15:0] w;
    rst = 1'b1; mem_ready = 1'b0; data_in = 16'h0000; cc = 4'h0;
    cur_ir = 16'h0000;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rst_e = fetch_exp(16'h0000, 1'b1, 1'b1);

    // Reset held three cycles, then two stalled fetch cycles.
    for (int i = 0; i < 3; i++)
      cycle(rst_e, "reset_hold", 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
    for (int i = 0; i < 2; i++)
      cycle(fetch_exp(cur_ir, 1'b0, 1'b0), "first_fetch_stall", 1'b1, 1'b0, 16'($urandom), 4'($urandom));

    // Directed instructions.
    run_instr(16'h1A4D, 0, 0, 4'($urandom));
    run_instr(16'h1130, 1, 0, 4'($urandom));
    run_instr(16'hE7FE, 0, 0, 4'b0100);
    run_instr(16'hE7FE, 0, 0, 4'b0000);
    run_instr(16'hC0A0, 0, 2, 4'($urandom));
    run_instr(16'hC8A0, 1, 1, 4'($urandom));
    run_instr(16'h0810, 0, 0, 4'($urandom));
    run_instr(16'hE080, 0, 0, 4'($urandom));

    // Randomised instruction stream.
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
    end

    // Reset while a store is stalled in MEMORY.
    cycle(fetch_exp(cur_ir, 1'b1, 1'b0), "fetch_done", 1'b1, 1'b1, 16'hC8A0, 4'($urandom));
    cur_ir = 16'hC8A0;
    cycle(exec_exp(16'hC8A0, 4'h0), "execute", 1'b1, 1'b0, 16'($urandom), 4'h0);
    cycle(mem_exp(16'hC8A0, 1'b0), "mem_stall", 1'b1, 1'b0, 16'($urandom), 4'h0);
    chk("st_wen_before_reset", {15'd0, mem_wen}, 16'h0001);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("abort_mem_wen", {15'd0, mem_wen}, 16'h0000);
    chk("abort_fetch", {15'd0, fetch}, 16'h0001);
    chk("abort_ir", ir, 16'h0000);
    cycle(rst_e, "abort_reset_hold", 1'b0, 1'b1, 16'($urandom), 4'($urandom));
    cur_ir = 16'h0000;
    cycle(fetch_exp(cur_ir, 1'b0, 1'b0), "post_abort_stall", 1'b1, 1'b0, 16'($urandom), 4'($urandom));
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      run_instr(w, $urandom_range(0, 1), $urandom_range(0, 2), 4'($urandom));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
